// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding, opcode constants and ALU codes for the datapath sequencer
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles and flags the last one allowed
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clear_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  end
  // fires during the MEM_TIMEOUT-th waiting cycle, so the caller can still let mem_ready win
  assign timeout_o = en_i && (cnt_q == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle fetch/decode/execute/mem/writeback control FSM
module datapath_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [6:0]       opcode_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ir_write_o,
  output logic             reg_write_o,
  output logic             alu_src_o,
  output logic             mem_to_reg_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic [1:0]       alu_op_o,
  output logic             branch_o,
  output logic             busy_o,
  output logic             illegal_o,
  output logic             bus_error_o,
  output logic [CNT_W-1:0] instr_count_o
);
  state_e           state_q, state_d, next_instr;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d, bus_err_q, bus_err_d;
  logic             tmr_en, timeout, retire, is_load, is_ldst, is_br;
  assign tmr_en     = (state_q inside {FETCH, MEM}) && !mem_ready_i;
  assign is_load    = op_q == OP_LOAD;
  assign is_ldst    = is_load || op_q == OP_STORE;
  assign is_br      = op_q == OP_BRANCH;
  assign next_instr = stop_i ? IDLE : FETCH;
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!tmr_en),
    .en_i      (tmr_en),
    .timeout_o (timeout)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_op_o     = ALU_ADD;
    branch_o     = 1'b0;
    case (state_q)
      IDLE: state_d = (start_i && !stop_i) ? FETCH : IDLE;
      FETCH: begin
        mem_read_o = 1'b1;
        pc_write_o = mem_ready_i;
        ir_write_o = mem_ready_i;
        state_d    = mem_ready_i ? DECODE : timeout ? HALT : FETCH;
        bus_err_d  = bus_err_q || timeout;
      end
      DECODE: begin
        op_d      = opcode_i;
        state_d   = is_legal(opcode_i) ? EXECUTE : HALT;
        illegal_d = illegal_q || !is_legal(opcode_i);
      end
      EXECUTE: begin
        alu_op_o  = is_br ? ALU_BR : is_ldst ? ALU_ADD : ALU_FN;
        alu_src_o = is_ldst || op_q == OP_I;
        branch_o  = is_br;
        retire    = is_br;
        state_d   = is_br ? next_instr : is_ldst ? MEM : WRITEBACK;
      end
      MEM: begin
        mem_read_o  = is_load;
        mem_write_o = !is_load;
        retire      = mem_ready_i && !is_load;
        state_d     = mem_ready_i ? (is_load ? WRITEBACK : next_instr) : timeout ? HALT : MEM;
        bus_err_d   = bus_err_q || timeout;
      end
      WRITEBACK: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = is_load;
        retire       = 1'b1;
        state_d      = next_instr;
      end
      HALT: begin
        state_d   = start_i ? FETCH : HALT;
        illegal_d = illegal_q && !start_i;
        bus_err_d = bus_err_q && !start_i;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cnt_d         = cnt_q + CNT_W'(retire);
  assign busy_o        = state_q != IDLE && state_q != HALT;
  assign illegal_o     = illegal_q;
  assign bus_error_o   = bus_err_q;
  assign instr_count_o = cnt_q;
endmodule
